uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one byte-wide UART transmitter between NUM_REQ requesters.
- Each requester offers a 32-bit status word. The block grants one requester, frames its word into a byte packet and feeds the packet to the transmitter one byte at a time.
- Uses the transmitter's DV / Active / Done handshake.
- Sits between the motor-board status sources (encoder, current, PWM monitors) and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..8.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Req  in  NUM_REQ  request per requester; held high until acked
- i_Data  in  32*NUM_REQ  payload; requester k occupies bits [32k+31:32k]
- o_Ack  out  NUM_REQ  one-cycle pulse; payload of that requester captured
- o_Busy  out  1  high from grant until the last frame byte's Done has fallen
- o_Grant_Id  out  3  id of the current/last granted requester
- o_Tx_DV  out  1  one-cycle byte-valid strobe to the transmitter
- o_Tx_Byte  out  8  byte to the transmitter; stable while o_Tx_DV is high
- i_Tx_Active  in  1  transmitter busy
- i_Tx_Done  in  1  transmitter done; may stay high more than one cycle

Behaviour:
- Reset values: o_Ack=0, o_Busy=0, o_Grant_Id=0, o_Tx_DV=0, o_Tx_Byte=0. Round-robin pointer=0, state=SYNC.
- Frame format: HEADER, {5'b0, id}, D[31:24], D[23:16], D[15:8], D[7:0]. CHK is appended as a 7th byte when UART_TX_SCHED_CHK_EN is defined.
- SYNC: wait until i_Tx_Active=0 and i_Tx_Done=0, then go to IDLE. The transmitter has no reset, so this guards a byte still in flight across our reset.
- IDLE: if any i_Req is set, scan from the pointer upward, wrapping modulo NUM_REQ; the first set bit wins.
  - Next cycle: o_Ack[win]=1 for exactly one cycle, payload latched, o_Grant_Id=win, o_Busy=1, pointer=(win+1) mod NUM_REQ, byte index=0, state=SEND.
- SEND: o_Tx_DV=1 for one cycle with o_Tx_Byte=frame[index]; then state=WAIT_DONE.
- WAIT_DONE: wait for i_Tx_Done=1; then state=WAIT_LOW.
- WAIT_LOW: wait for i_Tx_Done=0.
  - If index is the last byte: o_Busy=0, state=IDLE.
  - Otherwise: index+1, state=SEND.
- Consequence: DV is never issued while the transmitter is outside its idle state.
- Latency: request seen in IDLE at cycle t gives o_Ack at t+1 and first o_Tx_DV at t+2.
- Fairness: requests arriving mid-frame wait. Any requester that holds i_Req is served within NUM_REQ frames.
- All requesters requesting at once: served 0,1,2,3,0,... starting from the pointer.
- A requester that drops i_Req before the IDLE sampling cycle is not granted. No ack is owed.
- Payload is latched only at grant. Changes to i_Data after o_Ack do not affect the frame in flight.
- i_Req is ignored outside IDLE. o_Ack is never asserted for a requester whose i_Req was low at arbitration.
- Reset asserted mid-frame: every output goes to its reset value immediately (asynchronous). The frame is abandoned and no ack is repeated. After release the block passes through SYNC.
- NUM_REQ=1: the pointer stays at 0 and behaviour is otherwise identical.

Optional Feature:
- Macro: UART_TX_SCHED_CHK_EN.
- Defined: 7-byte frame; CHK = XOR of bytes 1..5 (id byte and the four data bytes).
- Undefined: 6-byte frame, no checksum logic.

Decomposition:
- Shared package (uart_tx_sched_pkg): state encodings (SYNC, IDLE, SEND, WAIT_DONE, WAIT_LOW), HEADER default, frame-length constants (6 and 7), ID width (3).
- One natural sub-module: rr_arbiter. Inputs: request vector and pointer. Outputs: one-hot grant, grant index and any-grant flag. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single request, no checksum: i_Req=4'b0010, i_Data[63:32]=32'h12345678 → o_Ack[1] one cycle; byte stream A5, 01, 12, 34, 56, 78; o_Busy falls after the 6th Done falls.
- Checksum enabled: i_Req[0] with 32'hDEADBEEF → bytes A5, 00, DE, AD, BE, EF, then CHK = 00^DE^AD^BE^EF = 8'h22.
- Fairness: all four requests held high for 8 frames → grant order 0,1,2,3,0,1,2,3; each o_Ack pulses exactly twice.
- Handshake: transmitter model holds Done high for 2 cycles → exactly one DV per byte; next DV only after Done has fallen; o_Tx_Byte stable during DV.
- Reset mid-frame: assert i_Reset during byte 3 while model i_Tx_Active=1 → outputs zero at once; no DV after release until Active=0 and Done=0; then a pending i_Req[2] is served with pointer restarted at 0.
- Data change after ack: modify i_Data[31:0] one cycle after o_Ack[0] → transmitted frame carries the old value.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_WAIT_LOW
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN_BASE = 6;
  localparam int         FRAME_LEN_CHK  = 7;
  localparam int         ID_W           = 3;

  // Checksum over the id byte and the four payload bytes (header excluded).
  function automatic logic [7:0] frame_chk(input logic [ID_W-1:0] id, input logic [31:0] d);
    return {{(8-ID_W){1'b0}}, id} ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module uart_tx_scheduler_rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set request is the last one written.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        gnt      = '0;
        gnt[j]   = 1'b1;
        gnt_idx  = ID_W'(j);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler framing 32-bit status words onto a shared byte UART transmitter.
// Define UART_TX_SCHED_CHK_EN to append an XOR checksum byte (7-byte frames instead of 6).
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int         NUM_REQ = 4,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req,
  input  logic [32*NUM_REQ-1:0]  i_Data,
  output logic [NUM_REQ-1:0]     o_Ack,
  output logic                   o_Busy,
  output logic [2:0]             o_Grant_Id,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
);

`ifdef UART_TX_SCHED_CHK_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                dv_q, dv_d;
  logic [7:0]          byte_q, byte_d;
  logic [31:0]         data_q, data_d;
  logic [2:0]          idx_q, idx_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [31:0]         req_data;
  logic [7:0]          frame_byte;

  uart_tx_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (i_Req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    req_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) req_data = i_Data[32*k +: 32];
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = {{(8-ID_W){1'b0}}, id_q};
      3'd2:    frame_byte = data_q[31:24];
      3'd3:    frame_byte = data_q[23:16];
      3'd4:    frame_byte = data_q[15:8];
      3'd5:    frame_byte = data_q[7:0];
`ifdef UART_TX_SCHED_CHK_EN
      3'd6:    frame_byte = frame_chk(id_q, data_q);
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  // One byte in flight at a time: DV only after the previous Done has both risen and fallen.
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    busy_d  = busy_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      ST_SYNC: begin
        if (!i_Tx_Active && !i_Tx_Done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (gnt_any) begin
          ack_d   = gnt;
          data_d  = req_data;
          id_d    = gnt_idx;
          busy_d  = 1'b1;
          ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        dv_d    = 1'b1;
        byte_d  = frame_byte;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!i_Tx_Done) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_SYNC;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
      data_q  <= 32'h0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign o_Ack      = ack_q;
  assign o_Busy     = busy_q;
  assign o_Grant_Id = id_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;

endmodule
